ibex_tb_multiport_mem: RTL and testbench



---
 rtl/ibex_tb_mem_pkg.sv | 25 ++
 rtl/ibex_tb_rr_arb.sv | 56 +++++
 rtl/prim_secded_inv_39_32_enc.sv | 23 ++
 rtl/ibex_tb_multiport_mem.sv | 180 ++++++++++++++++++
 tb/tb_ibex_tb_multiport_mem.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_tb_mem_pkg.sv
// Shared types and helpers for the multi-port simulation memory.
//   resp_stage_t : one slot of the response pipeline {valid, port, err, data}
//   idx_width()  : index width for an N-entry selection (at least 1 bit)
//   MemIdxW      : word-index width of the default-sized array
package ibex_tb_mem_pkg;

  localparam int unsigned MaxPorts = 4;
  // Wide enough to name any of MaxPorts ports.
  localparam int unsigned PortIdxW = 2;
  localparam int unsigned DefaultDepth = 16384;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned MemIdxW = idx_width(DefaultDepth);

  typedef struct packed {
    logic                valid;
    logic [PortIdxW-1:0] port;
    logic                err;
    logic [31:0]         data;
  } resp_stage_t;

endpackage

// File: rtl/ibex_tb_rr_arb.sv
// Round-robin arbiter.
//   clk_i, rst_ni : clock, async active-low reset
//   eligible_i    : per-port eligibility
//   gnt_o         : one-hot grant (or zero), combinational from eligible_i
//   gnt_idx_o     : index of the granted port
//   gnt_any_o     : a grant was issued this cycle
// The pointer names the highest-priority port and moves to winner+1 on each grant.
module ibex_tb_rr_arb
  import ibex_tb_mem_pkg::*;
#(
  parameter int unsigned NumPorts = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumPorts-1:0]              eligible_i,
  output logic [NumPorts-1:0]              gnt_o,
  output logic [idx_width(NumPorts)-1:0]   gnt_idx_o,
  output logic                             gnt_any_o
);

  localparam int unsigned IdxW = idx_width(NumPorts);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NumPorts);
      if (!gnt_any_o && eligible_i[cand]) begin
        gnt_any_o     = 1'b1;
        gnt_o[cand]   = 1'b1;
        gnt_idx_o     = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (gnt_idx_o == IdxW'(NumPorts - 1)) ? '0 : gnt_idx_o + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao SECDED(39,32) encoder.
//   data_i : 32-bit payload
//   data_o : {7 inverted check bits, payload}
module prim_secded_inv_39_32_enc (
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  logic [6:0] chk;

  always_comb begin
    chk[0] = ^(data_i & 32'h2606_BD25);
    chk[1] = ^(data_i & 32'hDEBA_8050);
    chk[2] = ^(data_i & 32'h413D_89AA);
    chk[3] = ^(data_i & 32'h3123_4ED1);
    chk[4] = ^(data_i & 32'hC2C1_323B);
    chk[5] = ^(data_i & 32'h2DCC_624C);
    chk[6] = ^(data_i & 32'h9850_5586);
    // Inversion keeps an all-zero word from having an all-zero code.
    data_o = {chk ^ 7'h2A, data_i};
  end

endmodule

// File: rtl/ibex_tb_multiport_mem.sv
// Multi-port simulation memory responder with Ibex req/gnt/rvalid buses.
//   clk_i, rst_ni        : clock, async active-low reset
//   req_i/we_i/be_i      : per-port request, write enable, byte enables
//   addr_i/wdata_i       : per-port byte address (bits [1:0] ignored), write data
//   gnt_o                : per-port grant, combinational, at most one-hot
//   rvalid_o/rdata_o     : per-port response valid and read data
//   rdata_intg_o         : inverted SECDED(39,32) check bits of rdata_o
//   err_o                : out-of-range access, valid with rvalid_o
//   bd_we_i/bd_addr_i/bd_wdata_i : backdoor full-word write, wins over all ports
module ibex_tb_multiport_mem
  import ibex_tb_mem_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned Depth          = 16384,
  parameter logic [31:0] AddrBase       = 32'h0010_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumPorts-1:0]       req_i,
  input  logic [NumPorts-1:0]       we_i,
  input  logic [NumPorts-1:0][3:0]  be_i,
  input  logic [NumPorts-1:0][31:0] addr_i,
  input  logic [NumPorts-1:0][31:0] wdata_i,
  output logic [NumPorts-1:0]       gnt_o,
  output logic [NumPorts-1:0]       rvalid_o,
  output logic [NumPorts-1:0][31:0] rdata_o,
  output logic [NumPorts-1:0][6:0]  rdata_intg_o,
  output logic [NumPorts-1:0]       err_o,
  input  logic                      bd_we_i,
  input  logic [31:0]               bd_addr_i,
  input  logic [31:0]               bd_wdata_i
);

  localparam int unsigned MemAw = idx_width(Depth);
  localparam int unsigned PortW = idx_width(NumPorts);
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] SpanBytes = 33'(Depth) << 2;

  function automatic logic addr_hit(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, AddrBase};
    // off[32] is the borrow: addr below AddrBase.
    return !off[32] && (off < SpanBytes);
  endfunction

  function automatic logic [MemAw-1:0] addr_idx(input logic [31:0] addr);
    return MemAw'((addr - AddrBase) >> 2);
  endfunction

  // Arbitration
  logic [NumPorts-1:0]           eligible;
  logic [NumPorts-1:0]           retire;
  logic [NumPorts-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [PortW-1:0]              gnt_idx;
  logic                          gnt_any;

  always_comb begin
    eligible = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      // A retiring response frees its slot in the same cycle.
      eligible[p] = req_i[p] && !bd_we_i &&
                    ((32'(cnt_q[p]) < MaxOutstanding) || retire[p]);
    end
  end

  ibex_tb_rr_arb #(
    .NumPorts (NumPorts)
  ) u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .eligible_i (eligible),
    .gnt_o      (gnt_o),
    .gnt_idx_o  (gnt_idx),
    .gnt_any_o  (gnt_any)
  );

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (gnt_o[p] && !retire[p]) begin
        cnt_d[p] = cnt_q[p] + CntW'(1);
      end else if (!gnt_o[p] && retire[p]) begin
        cnt_d[p] = cnt_q[p] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Selected access
  logic [31:0]      sel_addr, sel_wdata;
  logic [3:0]       sel_be;
  logic             sel_we, sel_hit;
  logic [MemAw-1:0] sel_idx;
  logic             bd_hit;
  logic [MemAw-1:0] bd_idx;

  assign sel_addr  = addr_i[gnt_idx];
  assign sel_wdata = wdata_i[gnt_idx];
  assign sel_be    = be_i[gnt_idx];
  assign sel_we    = we_i[gnt_idx];
  assign sel_hit   = addr_hit(sel_addr);
  assign sel_idx   = addr_idx(sel_addr);
  assign bd_hit    = addr_hit(bd_addr_i);
  assign bd_idx    = addr_idx(bd_addr_i);

  // Storage is deliberately not reset so contents survive a mid-run reset.
  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (bd_we_i) begin
      if (bd_hit) begin
        mem_q[bd_idx] <= bd_wdata_i;
      end
    end else if (gnt_any && sel_hit && sel_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_be[b]) begin
          mem_q[sel_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline
  resp_stage_t new_resp;
  resp_stage_t pipe_q [Latency];
  resp_stage_t out_stage;

  always_comb begin
    new_resp       = '0;
    new_resp.valid = gnt_any;
    new_resp.port  = PortIdxW'(gnt_idx);
    new_resp.err   = gnt_any && !sel_hit;
    if (gnt_any && sel_hit && !sel_we) begin
      new_resp.data = mem_q[sel_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Latency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= new_resp;
      for (int unsigned i = 1; i < Latency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_stage = pipe_q[Latency-1];
  assign rvalid_o  = retire;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [31:0] port_data;
    logic [38:0] enc;

    assign retire[p] = out_stage.valid && (out_stage.port == PortIdxW'(p));
    assign port_data = retire[p] ? out_stage.data : 32'h0;
    assign err_o[p]  = retire[p] && out_stage.err;

    prim_secded_inv_39_32_enc u_enc (
      .data_i (port_data),
      .data_o (enc)
    );

    assign rdata_o[p]      = enc[31:0];
    assign rdata_intg_o[p] = enc[38:32];
  end

endmodule

// File: tb/tb_ibex_tb_multiport_mem.sv
// Randomized scoreboard bench for ibex_tb_multiport_mem.
module tb_ibex_tb_multiport_mem;

  localparam int unsigned NP    = 2;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] BASE  = 32'h0010_0000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP-1:0]       req, we;
  logic [NP-1:0][3:0]  be;
  logic [NP-1:0][31:0] addr, wdata;
  logic [NP-1:0]       gnt, rvalid, err;
  logic [NP-1:0][31:0] rdata;
  logic [NP-1:0][6:0]  intg;
  logic                bd_we;
  logic [31:0]         bd_addr, bd_wdata;

  always #5 clk = ~clk;

  ibex_tb_multiport_mem #(
    .NumPorts       (NP),
    .Depth          (DEPTH),
    .AddrBase       (BASE),
    .Latency        (LAT),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .we_i         (we),
    .be_i         (be),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .rdata_intg_o (intg),
    .err_o        (err),
    .bd_we_i      (bd_we),
    .bd_addr_i    (bd_addr),
    .bd_wdata_i   (bd_wdata)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q [NP][$];
  int          due_m [NP][$];
  logic [31:0] mem_m [DEPTH];
  int          ptr_m = 0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        dir_en = 1'b0;
  logic [1:0]  dir_gnt = 2'b00;
  logic        drain_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hsiao(39,32) check bits with the inverted-code constant applied.
  function automatic logic [6:0] intg_of(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  r;
    m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
          32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    for (int i = 0; i < 7; i++) r[i] = ^(d & m[i]);
    return r ^ 7'h2A;
  endfunction

  // Reference model: predicts the grant and the response it will produce.
  always @(negedge clk) begin : model
    logic [1:0] want;
    int         win;
    int         idx;
    longint     a;
    exp_t       e;
    if (!rst_n) begin
      ptr_m = 0;
      for (int p = 0; p < NP; p++) due_m[p].delete();
    end else begin
      for (int p = 0; p < NP; p++)
        while (due_m[p].size() > 0 && due_m[p][0] < cyc) void'(due_m[p].pop_front());
      win = -1;
      if (!bd_we) begin
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (ptr_m + k) % NP;
          if (win < 0 && req[p] &&
              (due_m[p].size() < MAXO || due_m[p][0] == cyc)) win = p;
        end
      end
      want = (win >= 0) ? 2'(1 << win) : 2'b00;
      checks++;
      if (gnt !== want) begin
        errors++;
        $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt, want);
      end
      if (dir_en) begin
        checks++;
        if (gnt !== dir_gnt) begin
          errors++;
          $display("FAIL gnt_pattern cyc=%0d got=%b want=%b", cyc, gnt, dir_gnt);
        end
      end
      if (win >= 0) begin
        a      = {32'd0, addr[win]};
        e.due  = cyc + LAT;
        e.err  = 1'b0;
        e.data = 32'h0;
        if (a < BASE || a >= BASE + 4 * DEPTH) begin
          e.err = 1'b1;
        end else begin
          idx = int'((a - BASE) / 4);
          if (we[win]) begin
            for (int b = 0; b < 4; b++)
              if (be[win][b]) mem_m[idx][8*b +: 8] = wdata[win][8*b +: 8];
          end else begin
            e.data = mem_m[idx];
          end
        end
        exp_q[win].push_back(e);
        due_m[win].push_back(e.due);
        ptr_m = (win + 1) % NP;
      end
      if (bd_we) begin
        a = {32'd0, bd_addr};
        if (a >= BASE && a < BASE + 4 * DEPTH) mem_m[int'((a - BASE) / 4)] = bd_wdata;
      end
    end
  end

  // Monitor: pops expected responses as the DUT presents them.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) exp_q[p].delete();
      checks++;
      if (gnt !== '0 || rvalid !== '0 || err !== '0 || rdata !== '0 ||
          intg !== {2{intg_of(32'd0)}}) begin
        errors++;
        $display("FAIL reset_state got gnt=%b rvalid=%b err=%b rdata=%h intg=%h want zeros intg=%h",
                 gnt, rvalid, err, rdata, intg, {2{intg_of(32'd0)}});
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        while (exp_q[p].size() > 0 && exp_q[p][0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_rvalid port=%0d got none want due=%0d", p, exp_q[p][0].due);
          void'(exp_q[p].pop_front());
        end
        if (rvalid[p]) begin
          checks++;
          if (exp_q[p].size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid port=%0d cyc=%0d got rvalid=1 want 0", p, cyc);
          end else begin
            e = exp_q[p].pop_front();
            if (e.due != cyc || rdata[p] !== e.data || err[p] !== e.err ||
                intg[p] !== intg_of(e.data)) begin
              errors++;
              $display("FAIL resp port=%0d got cyc=%0d data=%h err=%b intg=%h want cyc=%0d data=%h err=%b intg=%h",
                       p, cyc, rdata[p], err[p], intg[p], e.due, e.data, e.err, intg_of(e.data));
            end
          end
        end
        if (drain_chk) begin
          checks++;
          if (exp_q[p].size() != 0) begin
            errors++;
            $display("FAIL drain port=%0d got pending=%0d want 0", p, exp_q[p].size());
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port_op(input int p, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 11);
    if (r < 9)       return 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3));
    else if (r == 9) return 32'(BASE + 4 * DEPTH + $urandom_range(0, 3));
    else if (r == 10) return 32'(BASE - 4 + $urandom_range(0, 3));
    else             return $urandom();
  endfunction

  logic [1:0] stall_pat [5];

  initial begin
    stall_pat = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Backdoor preload; port requests in these cycles must not be granted.
    for (int i = 0; i < int'(DEPTH); i++) begin
      idle_inputs();
      bd_we    = 1'b1;
      bd_addr  = 32'(BASE + 4 * i);
      bd_wdata = (i == 0) ? 32'h0 : (i == 2) ? 32'hDEAD_BEEF : $urandom();
      req      = 2'($urandom_range(0, 3));
      addr[0]  = rand_addr();
      addr[1]  = rand_addr();
      tick();
    end
    idle_inputs();
    bd_we = 1'b1; bd_addr = 32'(BASE + 4 * DEPTH); bd_wdata = 32'hFFFF_FFFF;
    tick();

    // Backdoor-loaded word read back.
    idle_inputs(); port_op(0, 1'b0, 4'hF, BASE + 32'd8, 32'h0); tick();
    idle_inputs(); repeat (LAT + 1) tick();

    // Single port saturating the outstanding limit.
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      port_op(1, 1'b0, 4'hF, 32'(BASE + 4 * i), 32'h0);
      dir_en = 1'b1; dir_gnt = stall_pat[i];
      tick();
    end
    dir_en = 1'b0; idle_inputs(); repeat (LAT + 1) tick();

    // Byte write then read-back on port 1.
    idle_inputs(); port_op(1, 1'b1, 4'b0010, BASE, 32'h0000_AB00); tick();
    idle_inputs(); port_op(1, 1'b0, 4'hF, BASE, 32'h0); tick();
    idle_inputs(); repeat (LAT + 1) tick();

    // Just past the top, and just below the base.
    idle_inputs(); port_op(0, 1'b0, 4'hF, 32'(BASE + 4 * DEPTH), 32'h0); tick();
    idle_inputs(); port_op(0, 1'b0, 4'hF, BASE - 32'd4, 32'h0); tick();
    idle_inputs(); repeat (LAT + 1) tick();

    // Reset with two responses in flight.
    idle_inputs(); port_op(0, 1'b0, 4'hF, BASE + 32'd12, 32'h0); tick();
    idle_inputs(); port_op(1, 1'b0, 4'hF, BASE + 32'd16, 32'h0); tick();
    idle_inputs(); rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1;

    // Both ports busy right after release: strict alternation from port 0.
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      port_op(0, 1'b0, 4'hF, 32'(BASE + 4 * i), 32'h0);
      port_op(1, 1'b0, 4'hF, 32'(BASE + 4 * (i + 8)), 32'h0);
      dir_en = 1'b1; dir_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
    end
    dir_en = 1'b0; idle_inputs(); repeat (LAT + 1) tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      for (int p = 0; p < int'(NP); p++)
        if ($urandom_range(0, 3) != 0)
          port_op(p, 1'($urandom_range(0, 1)), 4'($urandom()), rand_addr(), $urandom());
      if ($urandom_range(0, 9) == 0) begin
        bd_we = 1'b1; bd_addr = rand_addr(); bd_wdata = $urandom();
      end
      tick();
    end

    idle_inputs(); repeat (LAT + 2) tick();
    drain_chk = 1'b1; tick(); drain_chk = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
